// File: rtl/fixed_weight_loc_to_vec_if.sv
// Signal bundle between the location-to-vector expander and its surroundings:
// control handshake, location-memory read port and vector read port.
interface fixed_weight_loc_to_vec_if #(
   parameter int M          = 16,
   parameter int LOG_WEIGHT = 8,
   parameter int WIDTH      = 32,
   parameter int ADDR_W     = 11
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  err_range;
   logic                  rd_error_loc;
   logic [LOG_WEIGHT-1:0] rd_addr_error_loc;
   logic [M-1:0]          error_loc;
   logic                  vec_rd;
   logic [ADDR_W-1:0]     vec_rd_addr;
   logic [WIDTH-1:0]      vec_dout;

   modport master (
      output start, error_loc, vec_rd, vec_rd_addr,
      input  busy, done, err_range, rd_error_loc, rd_addr_error_loc, vec_dout
   );

   modport slave (
      input  start, error_loc, vec_rd, vec_rd_addr,
      output busy, done, err_range, rd_error_loc, rd_addr_error_loc, vec_dout
   );
endinterface

// File: rtl/fixed_weight_loc_to_vec.sv
// Expands WEIGHT error locations into a dense N-bit vector RAM: clear pass,
// then a one-location-per-cycle read-modify-write pipeline with forwarding.
module fixed_weight_loc_to_vec #(
   parameter int N          = 57637,
   parameter int M          = 16,
   parameter int WEIGHT     = 149,
   parameter int LOG_WEIGHT = $clog2(WEIGHT),
   parameter int WIDTH      = 32,
   parameter int DEPTH      = (N + WIDTH - 1) / WIDTH,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input logic                       clk,
   input logic                       rst,
   fixed_weight_loc_to_vec_if.slave  bus
);
   localparam int LOG_WIDTH = $clog2(WIDTH);
   localparam int CNT_W     = $clog2(((DEPTH > WEIGHT) ? DEPTH : WEIGHT) + 1);
   localparam logic [CNT_W-1:0]  CLEAR_LAST  = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  EXPAND_LAST = CNT_W'(WEIGHT - 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(2);
   localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, EXPAND, DRAIN} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               start_ok;

   logic               s2_valid_reg;
   logic               s2_inrange;
   logic [ADDR_W-1:0]  s2_word;
   logic               s3_valid_reg, s3_inrange_reg;
   logic [ADDR_W-1:0]  s3_word_reg;
   logic [LOG_WIDTH-1:0] s3_bit_reg;
   logic               s3_write;
   logic [WIDTH-1:0]   s3_base, s3_data;
   logic               fwd_valid_reg;
   logic [ADDR_W-1:0]  fwd_word_reg;
   logic [WIDTH-1:0]   fwd_data_reg;
   logic               err_range_reg;

   logic [WIDTH-1:0]   ram [DEPTH];
   logic [WIDTH-1:0]   rd_data_reg;
   logic [WIDTH-1:0]   ram_b_reg;
   logic               vec_sel_reg;
   logic               ram_we;
   logic [ADDR_W-1:0]  ram_waddr;
   logic [WIDTH-1:0]   ram_wdata;
   logic               vec_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      start_ok   = 1'b0;
      case (state_reg)
         IDLE: if (bus.start) begin
            start_ok   = 1'b1;
            state_next = CLEAR;
            cnt_next   = '0;
         end
         CLEAR: if (cnt_reg == CLEAR_LAST) begin
            state_next = EXPAND;
            cnt_next   = '0;
         end else cnt_next = cnt_reg + 1'b1;
         EXPAND: if (cnt_reg == EXPAND_LAST) begin
            state_next = DRAIN;
            cnt_next   = '0;
         end else cnt_next = cnt_reg + 1'b1;
         DRAIN: if (cnt_reg == DRAIN_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
         end else cnt_next = cnt_reg + 1'b1;
         default: state_next = IDLE;
      endcase
   end

   // The final DRAIN cycle is the done cycle; busy is already low there.
   assign bus.done              = (state_reg == DRAIN) && (cnt_reg == DRAIN_LAST);
   assign bus.busy              = (state_reg != IDLE) && !bus.done;
   assign bus.rd_error_loc      = (state_reg == EXPAND);
   assign bus.rd_addr_error_loc = bus.rd_error_loc ? cnt_reg[LOG_WEIGHT-1:0] : '0;
   assign bus.err_range         = err_range_reg;

   assign s2_inrange = 32'(bus.error_loc) < 32'(N);
   assign s2_word    = ADDR_W'(bus.error_loc >> LOG_WIDTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_reg   <= 1'b0;
         s3_valid_reg   <= 1'b0;
         s3_inrange_reg <= 1'b0;
         s3_word_reg    <= '0;
         s3_bit_reg     <= '0;
         fwd_valid_reg  <= 1'b0;
         fwd_word_reg   <= '0;
         fwd_data_reg   <= '0;
         err_range_reg  <= 1'b0;
      end else begin
         s2_valid_reg   <= bus.rd_error_loc;
         s3_valid_reg   <= s2_valid_reg;
         s3_inrange_reg <= s2_inrange;
         s3_word_reg    <= s2_word;
         s3_bit_reg     <= bus.error_loc[LOG_WIDTH-1:0];
         fwd_valid_reg  <= s3_write;
         fwd_word_reg   <= s3_word_reg;
         fwd_data_reg   <= s3_data;
         if (start_ok)
            err_range_reg <= 1'b0;
         else if (s3_valid_reg && !s3_inrange_reg)
            err_range_reg <= 1'b1;
      end
   end

   // The S2 read of the following location misses the write landing on the
   // same edge, so the last written word is bypassed into S3.
   assign s3_write = s3_valid_reg && s3_inrange_reg;
   assign s3_base  = (fwd_valid_reg && (fwd_word_reg == s3_word_reg)) ? fwd_data_reg : rd_data_reg;
   assign s3_data  = s3_base | (WIDTH'(1) << s3_bit_reg);

   assign ram_we    = (state_reg == CLEAR) || s3_write;
   assign ram_waddr = (state_reg == CLEAR) ? cnt_reg[ADDR_W-1:0] : s3_word_reg;
   assign ram_wdata = (state_reg == CLEAR) ? '0 : s3_data;
   assign vec_ok    = bus.vec_rd && !bus.busy && (bus.vec_rd_addr <= LAST_WORD);

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[ram_waddr] <= ram_wdata;
      if (s2_valid_reg && s2_inrange)
         rd_data_reg <= ram[s2_word];
      if (vec_ok)
         ram_b_reg <= ram[bus.vec_rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         vec_sel_reg <= 1'b0;
      else if (bus.busy)
         vec_sel_reg <= 1'b0;
      else if (bus.vec_rd)
         vec_sel_reg <= vec_ok;
   end

   assign bus.vec_dout = vec_sel_reg ? ram_b_reg : '0;
endmodule
